// File: rtl/generic_ram_be_if.sv
// Request/response bundle for generic_ram_be. The RAM side uses the slave modport and the
// requester uses the master modport.
interface generic_ram_be_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [WIDTH/8-1:0] req_be;
    logic [AW-1:0]      req_addr;
    logic [WIDTH-1:0]   req_wdata;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_rdata;
    logic               rsp_err;
    logic               wr_err;
    logic               busy;

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, busy
    );

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, busy
    );
endinterface

// File: rtl/generic_ram_be.sv
// Single-port byte-enabled RAM with valid/ready requests, 1- or 2-cycle registered reads,
// an optional post-reset zeroing sweep and out-of-range address flagging.
module generic_ram_be #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter string       DATAFILE       = ""
) (
    input logic             clock,
    input logic             reset,
    generic_ram_be_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic [0:0] {StClear, StRun} state_e;
    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StRun;

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             clr_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             accept, wr_en, rd_en, in_range;
    logic             rd1_valid_q, rd1_err_q;
    logic [WIDTH-1:0] rd1_data_q;
    logic             wr_err_q;

    // Out-of-range addresses only exist when DEPTH leaves part of the address space unused.
    if (DEPTH == (32'd1 << AW)) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = (bus.req_addr < AW'(DEPTH));
    end

    assign bus.req_ready = (state_q == StRun);
    assign bus.busy      = (state_q == StClear);
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_en         = accept && bus.req_we && in_range;
    assign rd_en         = accept && !bus.req_we;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            StClear: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d   = StRun;
                    clr_ptr_d = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ResetState;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] = '0;
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.req_be[i]) mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // Data registers load only on a valid read so rsp_rdata holds between responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd1_valid_q <= 1'b0;
            rd1_err_q   <= 1'b0;
            rd1_data_q  <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            rd1_valid_q <= rd_en;
            wr_err_q    <= accept && bus.req_we && !in_range;
            if (rd_en) begin
                rd1_err_q  <= !in_range;
                rd1_data_q <= in_range ? mem_q[bus.req_addr] : '0;
            end
        end
    end

    assign bus.wr_err = wr_err_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic             rd2_valid_q, rd2_err_q;
        logic [WIDTH-1:0] rd2_data_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd2_valid_q <= 1'b0;
                rd2_err_q   <= 1'b0;
                rd2_data_q  <= '0;
            end else begin
                rd2_valid_q <= rd1_valid_q;
                if (rd1_valid_q) begin
                    rd2_err_q  <= rd1_err_q;
                    rd2_data_q <= rd1_data_q;
                end
            end
        end

        assign bus.rsp_valid = rd2_valid_q;
        assign bus.rsp_err   = rd2_err_q;
        assign bus.rsp_rdata = rd2_data_q;
    end else begin : g_lat1
        assign bus.rsp_valid = rd1_valid_q;
        assign bus.rsp_err   = rd1_err_q;
        assign bus.rsp_rdata = rd1_data_q;
    end
endmodule
